// File: rtl/wimax_deinterleaver.sv
// Receive-side WiMAX block deinterleaver: writes each block in permuted order into one of
// two ping-pong flop banks while the other bank streams out in original coded order.
module wimax_deinterleaver #(
  parameter  int NCBPS = 192,
  parameter  int NCPC  = 2,
  parameter  int D     = 16,
  localparam int S     = ((NCPC / 2) > 1) ? (NCPC / 2) : 1,
  localparam int IW    = $clog2(NCBPS)
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          valid_in,
  input  logic          data_in,
  output logic          ready_out,
  output logic          valid_out,
  output logic          data_out,
  output logic [IW-1:0] data_out_index,
  output logic          block_last,
  input  logic          ready_in
);

  localparam int            CW   = $clog2(D * NCBPS) + 1;
  localparam logic [IW-1:0] LAST = IW'(NCBPS - 1);

  logic [NCBPS-1:0] bank [2];
  logic [1:0]       full;
  logic             wbank;
  logic             rbank;
  logic [IW-1:0]    wr_j;
  logic [IW-1:0]    rd_r;
  logic [IW-1:0]    wr_k;
  logic             wr_fire;
  logic             rd_fire;

  // Inverse of the two-step interleaver: received index j -> original coded index k.
  always_comb begin : write_map
    logic [CW-1:0] j_w;
    logic [CW-1:0] m;
    logic [CW-1:0] dm;
    j_w  = CW'(wr_j);
    m    = CW'(S) * (j_w / CW'(S)) + ((j_w + (CW'(D) * j_w) / CW'(NCBPS)) % CW'(S));
    dm   = CW'(D) * m;
    wr_k = IW'(dm - CW'(NCBPS - 1) * (dm / CW'(NCBPS)));
  end

  assign ready_out      = !full[wbank];
  assign valid_out      = full[rbank];
  assign data_out       = valid_out ? bank[rbank][rd_r] : 1'b0;
  assign data_out_index = rd_r;
  assign block_last     = valid_out && (rd_r == LAST);

  assign wr_fire = valid_in && ready_out;
  assign rd_fire = valid_out && ready_in;

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      full  <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      wr_j  <= '0;
      rd_r  <= '0;
    end else begin
      // Write and read always target different banks, so both full updates can land together.
      if (wr_fire) begin
        if (wr_j == LAST) begin
          wr_j        <= '0;
          full[wbank] <= 1'b1;
          wbank       <= ~wbank;
        end else begin
          wr_j <= wr_j + 1'b1;
        end
      end
      if (rd_fire) begin
        if (rd_r == LAST) begin
          rd_r        <= '0;
          full[rbank] <= 1'b0;
          rbank       <= ~rbank;
        end else begin
          rd_r <= rd_r + 1'b1;
        end
      end
    end
  end

  // NOTE: bank storage is deliberately not reset; the full flags gate every read of it.
  always_ff @(posedge clk) begin
    if (wr_fire) bank[wbank][wr_k] <= data_in;
  end

endmodule

// File: tb/tb_wimax_deinterleaver.sv
// Directed bench for wimax_deinterleaver: QPSK (S=1) and 16QAM (S=2) instances share one
// input stream; expectations come from the forward 802.16 interleaver applied to that stream.
module tb_wimax_deinterleaver;

  localparam int N = 192;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       valid_in = 1'b0;
  logic       data_in = 1'b0;
  logic       ready_in = 1'b0;
  logic       ready_out, valid_out, data_out, block_last;
  logic [7:0] data_out_index;
  logic       ready_out4, valid_out4, data_out4, block_last4;
  logic [7:0] data_out_index4;

  int   errors = 0;
  int   checks = 0;
  logic exp2[$];
  logic exp4[$];
  int   idx2 = 0, idx4 = 0;
  int   one_cnt = 0, one_idx = -1;
  int   stall_cycles = 0, bubbles = 0;
  bit   stream_mode = 1'b0, seen_valid = 1'b0;
  logic p_stall = 1'b0, p_d = 1'b0, p_l = 1'b0;
  logic [7:0] p_i = '0;

  always #5 clk = ~clk;

  wimax_deinterleaver #(.NCBPS(N), .NCPC(2), .D(16)) dut (
    .clk(clk), .resetN(resetN), .valid_in(valid_in), .data_in(data_in),
    .ready_out(ready_out), .valid_out(valid_out), .data_out(data_out),
    .data_out_index(data_out_index), .block_last(block_last), .ready_in(ready_in)
  );

  wimax_deinterleaver #(.NCBPS(N), .NCPC(4), .D(16)) dut4 (
    .clk(clk), .resetN(resetN), .valid_in(valid_in), .data_in(data_in),
    .ready_out(ready_out4), .valid_out(valid_out4), .data_out(data_out4),
    .data_out_index(data_out_index4), .block_last(block_last4), .ready_in(ready_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Forward interleaver: original coded index k -> transmitted position j.
  function automatic int fwd(input int k, input int s);
    int m;
    m = (N / 16) * (k % 16) + k / 16;
    return s * (m / s) + (m + N - (16 * m) / N) % s;
  endfunction

  // Output scoreboard and stall-hold checker, sampled mid-cycle.
  always @(negedge clk) begin
    if (!resetN) begin
      idx2 = 0;
      idx4 = 0;
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        check("hold_valid", valid_out, 1);
        check("hold_data", data_out, p_d);
        check("hold_idx", data_out_index, p_i);
        check("hold_last", block_last, p_l);
      end
      if (stream_mode) begin
        if (valid_out) seen_valid = 1'b1;
        else if (seen_valid) bubbles++;
      end
      if (valid_out && ready_in) begin
        if (exp2.size() == 0) begin
          checks++; errors++;
          $error("FAIL q2_extra observed=output expected=none");
        end else begin
          check("data2", data_out, exp2.pop_front());
        end
        check("idx2", data_out_index, idx2);
        check("last2", block_last, idx2 == N - 1);
        if (data_out) begin
          one_cnt++;
          one_idx = data_out_index;
        end
        idx2 = (idx2 == N - 1) ? 0 : idx2 + 1;
      end
      if (valid_out4 && ready_in) begin
        if (exp4.size() == 0) begin
          checks++; errors++;
          $error("FAIL q4_extra observed=output expected=none");
        end else begin
          check("data4", data_out4, exp4.pop_front());
        end
        check("idx4", data_out_index4, idx4);
        check("last4", block_last4, idx4 == N - 1);
        idx4 = (idx4 == N - 1) ? 0 : idx4 + 1;
      end
      p_stall = valid_out && !ready_in;
      p_d = data_out;
      p_i = data_out_index;
      p_l = block_last;
    end
  end

  task automatic send_bits(input logic [N-1:0] b, input int cnt, input bit push);
    int w;
    if (push) begin
      for (int k = 0; k < N; k++) begin
        exp2.push_back(b[fwd(k, 1)]);
        exp4.push_back(b[fwd(k, 2)]);
      end
    end
    for (int j = 0; j < cnt; j++) begin
      w = 0;
      valid_in = 1'b1;
      data_in = b[j];
      while (!ready_out && w < 2000) begin
        @(posedge clk); #1;
        w++;
        stall_cycles++;
      end
      if (w >= 2000) begin
        check("send_timeout", ready_out, 1);
        valid_in = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int n;
    n = 0;
    while ((exp2.size() != 0 || exp4.size() != 0) && n < 3000) begin
      ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    ready_in = 1'b1;
    check("drain_timeout", n < 3000, 1);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_ready"}, ready_out, 1);
    check({tag, "_valid"}, valid_out, 0);
    check({tag, "_data"}, data_out, 0);
    check({tag, "_idx"}, data_out_index, 0);
    check({tag, "_last"}, block_last, 0);
    check({tag, "_ready4"}, ready_out4, 1);
    check({tag, "_valid4"}, valid_out4, 0);
    check({tag, "_idx4"}, data_out_index4, 0);
  endtask

  task automatic walk(input int j, input int k);
    logic [N-1:0] b;
    b = '0;
    b[j] = 1'b1;
    one_cnt = 0;
    one_idx = -1;
    send_bits(b, N, 1'b1);
    drain(1'b0);
    check("walk_count", one_cnt, 1);
    check("walk_index", one_idx, k);
  endtask

  task automatic rand_block(output logic [N-1:0] b);
    for (int i = 0; i < N; i++) b[i] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [N-1:0] b;
    int n;
    ready_in = 1'b1;
    #12;
    chk_reset("reset");
    @(posedge clk); #1;
    resetN = 1'b1;
    @(posedge clk); #1;

    // Walking one, hand-derived positions.
    walk(60, 5);
    walk(1, 16);
    walk(12, 1);
    walk(191, 191);

    // Round trip of a random block.
    rand_block(b);
    send_bits(b, N, 1'b1);
    drain(1'b0);

    // Ten back-to-back blocks, free-running reader.
    stream_mode = 1'b1;
    seen_valid = 1'b0;
    bubbles = 0;
    stall_cycles = 0;
    rand_block(b);
    send_bits(b, N, 1'b1);
    check("first_valid", valid_out, 1);
    check("first_index", data_out_index, 0);
    for (int i = 0; i < 9; i++) begin
      rand_block(b);
      send_bits(b, N, 1'b1);
    end
    stream_mode = 1'b0;
    check("stream_stalls", stall_cycles, 0);
    check("stream_bubbles", bubbles, 0);
    drain(1'b0);

    // Backpressure: both banks fill, input stalls until block 0 drains.
    ready_in = 1'b0;
    rand_block(b);
    send_bits(b, N, 1'b1);
    rand_block(b);
    send_bits(b, N, 1'b1);
    check("bp_ready_low", ready_out, 0);
    rand_block(b);
    valid_in = 1'b1;
    data_in = b[0];
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("bp_still_low", ready_out, 0);
    check("bp_index_held", data_out_index, 0);
    ready_in = 1'b1;
    n = 0;
    while (!ready_out && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_release_cycles", n, 192);
    send_bits(b, N, 1'b1);
    drain(1'b0);

    // Reader stalls pseudo-randomly.
    ready_in = 1'b0;
    rand_block(b);
    send_bits(b, N, 1'b1);
    drain(1'b1);

    // Reset after 100 input bits, then a clean block.
    rand_block(b);
    send_bits(b, 100, 1'b0);
    resetN = 1'b0;
    #2;
    chk_reset("midreset");
    @(posedge clk); #1;
    resetN = 1'b1;
    @(posedge clk); #1;
    rand_block(b);
    send_bits(b, N, 1'b1);
    drain(1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("post_reset_idle", valid_out, 0);
    check("post_reset_idle4", valid_out4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
